// File: rtl/clock_input_conditioner.sv
// Button front end for the clock sequencer: synchronise, debounce and auto-repeat
// the two set-buttons, and derive the Tick time base (frozen while a button is held).

module clock_input_conditioner_chan #(
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int REPEAT_DELAY    = 16384,
    parameter int REPEAT_RATE     = 4096
) (
    input  logic Clock,
    input  logic nReset,
    input  logic btn_i,
    output logic level_o,
    output logic pulse_o
);
    localparam int DC_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RC_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RC_W   = (RC_MAX > 1) ? $clog2(RC_MAX) : 1;

    localparam logic [DC_W-1:0] DC_LAST    = DC_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RC_W-1:0] DELAY_LAST = RC_W'(REPEAT_DELAY - 1);
    localparam logic [RC_W-1:0] RATE_LAST  = RC_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_e;

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic [DC_W-1:0] dc_q, dc_d;
    state_e          state_q, state_d;
    logic [RC_W-1:0] rc_q, rc_d;
    logic            pulse_q, pulse_d;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            dc_q    <= '0;
            state_q <= IDLE;
            rc_q    <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            dc_q    <= dc_d;
            state_q <= state_d;
            rc_q    <= rc_d;
            pulse_q <= pulse_d;
        end
    end

    // Any sample that agrees with the accepted level restarts the stability count.
    always_comb begin
        level_d = level_q;
        dc_d    = dc_q;
        if (sync2_q == level_q) begin
            dc_d = '0;
        end else if (dc_q == DC_LAST) begin
            level_d = sync2_q;
            dc_d    = '0;
        end else begin
            dc_d = dc_q + 1'b1;
        end
    end

    // Release is tested before the terminal count so it wins over a due pulse.
    always_comb begin
        state_d = state_q;
        rc_d    = rc_q;
        pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                rc_d = '0;
                if (level_q) begin
                    pulse_d = 1'b1;
                    state_d = DELAY;
                end
            end
            DELAY: begin
                if (!level_q) begin
                    state_d = IDLE;
                    rc_d    = '0;
                end else if (rc_q == DELAY_LAST) begin
                    pulse_d = 1'b1;
                    rc_d    = '0;
                    state_d = REPEAT;
                end else begin
                    rc_d = rc_q + 1'b1;
                end
            end
            REPEAT: begin
                if (!level_q) begin
                    state_d = IDLE;
                    rc_d    = '0;
                end else if (rc_q == RATE_LAST) begin
                    pulse_d = 1'b1;
                    rc_d    = '0;
                end else begin
                    rc_d = rc_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                rc_d    = '0;
            end
        endcase
    end

    assign level_o = level_q;
    assign pulse_o = pulse_q;
endmodule

module clock_input_conditioner #(
    parameter int TICK_DIV        = 32768,
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int REPEAT_DELAY    = 16384,
    parameter int REPEAT_RATE     = 4096
) (
    input  logic Clock,
    input  logic nReset,
    input  logic BtnMin,
    input  logic BtnHour,
    output logic Tick,
    output logic SyncMinOut,
    output logic SyncHourOut,
    output logic SetActive
);
    localparam int PC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(TICK_DIV - 1);

    logic            level_min, level_hour, any_level;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            tick_q, tick_d;
    logic            set_active_q;

    clock_input_conditioner_chan #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_RATE    (REPEAT_RATE)
    ) u_min (
        .Clock  (Clock),
        .nReset (nReset),
        .btn_i  (BtnMin),
        .level_o(level_min),
        .pulse_o(SyncMinOut)
    );

    clock_input_conditioner_chan #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_RATE    (REPEAT_RATE)
    ) u_hour (
        .Clock  (Clock),
        .nReset (nReset),
        .btn_i  (BtnHour),
        .level_o(level_hour),
        .pulse_o(SyncHourOut)
    );

    assign any_level = level_min | level_hour;

    // Holding the prescaler at zero while setting restarts the time base on release.
    always_comb begin
        pc_d   = pc_q;
        tick_d = 1'b0;
        if (any_level) begin
            pc_d = '0;
        end else if (pc_q == PC_LAST) begin
            pc_d   = '0;
            tick_d = 1'b1;
        end else begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            pc_q         <= '0;
            tick_q       <= 1'b0;
            set_active_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            tick_q       <= tick_d;
            set_active_q <= any_level;
        end
    end

    assign Tick      = tick_q;
    assign SetActive = set_active_q;
endmodule

// File: tb/tb_clock_input_conditioner.sv
// Directed bench for clock_input_conditioner with small parameters; every expected
// pulse edge below is hand-derived from the sync/debounce/repeat/prescaler timing.

module tb_clock_input_conditioner;
    logic Clock = 1'b0;
    logic nReset;
    logic BtnMin;
    logic BtnHour;
    logic Tick;
    logic SyncMinOut;
    logic SyncHourOut;
    logic SetActive;

    int vectors    = 0;
    int miscompares = 0;
    int t          = 0;

    clock_input_conditioner #(
        .TICK_DIV       (8),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (16),
        .REPEAT_RATE    (4)
    ) dut (
        .Clock      (Clock),
        .nReset     (nReset),
        .BtnMin     (BtnMin),
        .BtnHour    (BtnHour),
        .Tick       (Tick),
        .SyncMinOut (SyncMinOut),
        .SyncHourOut(SyncHourOut),
        .SetActive  (SetActive)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp);
        end
    endtask

    task automatic check_all(input logic e_tick, input logic e_min,
                             input logic e_hour, input logic e_set);
        chk("tick", Tick, e_tick);
        chk("sync_min", SyncMinOut, e_min);
        chk("sync_hour", SyncHourOut, e_hour);
        chk("set_active", SetActive, e_set);
    endtask

    // Advance one rising edge; sample and drive 1 time unit after it.
    task automatic step();
        @(posedge Clock);
        #1;
        t++;
    endtask

    initial begin
        nReset  = 1'b0;
        BtnMin  = 1'b0;
        BtnHour = 1'b0;
        repeat (3) step();
        check_all(1'b0, 1'b0, 1'b0, 1'b0);

        nReset = 1'b1;
        t      = 0;

        // Edge t is the t-th rising edge after reset release; drives apply from edge t+1.
        for (int i = 0; i < 208; i++) begin
            step();
            check_all(t inside {8, 16, 24, 32, 40, 64, 72, 80, 134, 181},
                      t inside {47, 141, 157, 161, 165, 169, 188, 204, 208},
                      t inside {87, 103, 107, 111, 115, 119, 123,
                                144, 160, 164, 168, 172},
                      (t >= 47 && t <= 56) || (t >= 87 && t <= 126) ||
                      (t >= 141 && t <= 173) || (t >= 188));
            case (t)
                40:  BtnMin  = 1'b1;
                50:  BtnMin  = 1'b0;
                64:  BtnHour = 1'b1;
                65:  BtnHour = 1'b0;
                66:  BtnHour = 1'b1;
                67:  BtnHour = 1'b0;
                80:  BtnHour = 1'b1;
                120: BtnHour = 1'b0;
                134: BtnMin  = 1'b1;
                137: BtnHour = 1'b1;
                164: BtnMin  = 1'b0;
                167: BtnHour = 1'b0;
                181: BtnMin  = 1'b1;
                default: ;
            endcase
        end

        // Asynchronous reset while a repeat pulse is on the output.
        nReset = 1'b0;
        #1;
        check_all(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) begin
            step();
            check_all(1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Button still held: fresh press seen from the first edge after release.
        nReset = 1'b1;
        t      = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            check_all(1'b0, t == 7, 1'b0, t >= 7);
        end
        BtnMin = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
